// File: rtl/pll_lock_supervisor_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor and its interface.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    PLL_RST,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAIL
  } sup_state_e;

  localparam int RETRY_W = 4;

  typedef logic [RETRY_W-1:0] retry_t;

  // The down-counter only ever holds (cycles - 1), so $clog2 of the largest count suffices.
  function automatic int cnt_width(input int rst_cycles, input int timeout_cycles,
                                   input int stable_cycles);
    int largest;
    largest = rst_cycles;
    if (timeout_cycles > largest) largest = timeout_cycles;
    if (stable_cycles > largest) largest = stable_cycles;
    return (largest > 1) ? $clog2(largest) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Control/status bundle between the supervisor and the PLL / downstream reset consumers.
interface pll_lock_supervisor_if;
  import pll_sup_pkg::*;

  logic   pll_locked;
  logic   sw_relock;
  logic   pll_rst;
  logic   sys_rst_n;
  logic   lock_fail;
  retry_t retry_count;

  modport master (
    input  pll_locked,
    input  sw_relock,
    output pll_rst,
    output sys_rst_n,
    output lock_fail,
    output retry_count
  );

  modport slave (
    output pll_locked,
    output sw_relock,
    input  pll_rst,
    input  sys_rst_n,
    input  lock_fail,
    input  retry_count
  );

endinterface

// File: rtl/bit_sync_2ff.sv
// Generic two-flop synchronizer, cleared to 0 by an asynchronous active-low reset.
module bit_sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/pll_lock_supervisor.sv
// Drives the PLL reset, qualifies its lock output and releases the system reset once
// lock has been stable long enough; retries on timeout and latches a failure flag.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES      = 50,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 5000,
  parameter int MAX_RETRIES         = 3
) (
  input logic                   refclk,
  input logic                   rst_n,
  pll_lock_supervisor_if.master sup
);

  localparam int CNT_W = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t   RST_LOAD     = cnt_t'(PLL_RST_CYCLES - 1);
  localparam cnt_t   TIMEOUT_LOAD = cnt_t'(LOCK_TIMEOUT_CYCLES - 1);
  localparam cnt_t   STABLE_LOAD  = cnt_t'(LOCK_STABLE_CYCLES - 1);
  localparam retry_t RETRY_LIMIT  = retry_t'(MAX_RETRIES);

  sup_state_e state_q, state_d;
  cnt_t       cnt_q, cnt_d;
  retry_t     retry_q, retry_d;
  logic       pll_rst_q, pll_rst_d;
  logic       sys_rst_n_q, sys_rst_n_d;
  logic       lock_fail_q, lock_fail_d;
  logic       lk;

  bit_sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk  (refclk),
    .rst_n(rst_n),
    .d_i  (sup.pll_locked),
    .q_o  (lk)
  );

  function automatic cnt_t load_for(input sup_state_e s);
    case (s)
      PLL_RST:   return RST_LOAD;
      WAIT_LOCK: return TIMEOUT_LOAD;
      STABLE:    return STABLE_LOAD;
      default:   return '0;
    endcase
  endfunction

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= PLL_RST;
      cnt_q       <= RST_LOAD;
      retry_q     <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      lock_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retry_q     <= retry_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      lock_fail_q <= lock_fail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - cnt_t'(1) : cnt_q;

    case (state_q)
      PLL_RST: begin
        if (cnt_q == '0) state_d = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        // Lock seen on the timeout cycle wins over the retry.
        if (lk) begin
          state_d = STABLE;
        end else if (cnt_q == '0) begin
          retry_d = retry_q + retry_t'(1);
          state_d = (retry_d == RETRY_LIMIT) ? FAIL : PLL_RST;
        end
      end
      STABLE: begin
        if (!lk) state_d = WAIT_LOCK;
        else if (cnt_q == '0) state_d = RUN;
      end
      RUN: begin
        if (!lk || sup.sw_relock) state_d = PLL_RST;
      end
      FAIL: begin
        if (sup.sw_relock) begin
          retry_d = '0;
          state_d = PLL_RST;
        end
      end
      default: state_d = PLL_RST;
    endcase

    if (state_d != state_q) begin
      cnt_d = load_for(state_d);
      if (state_d == RUN) retry_d = '0;
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    pll_rst_d   = (state_d == PLL_RST);
    sys_rst_n_d = (state_d == RUN);
    lock_fail_d = (state_d == FAIL);
  end

  assign sup.pll_rst     = pll_rst_q;
  assign sup.sys_rst_n   = sys_rst_n_q;
  assign sup.lock_fail   = lock_fail_q;
  assign sup.retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bring-up/loss/timeout/recovery scenarios plus random lock activity,
// checked every cycle against a phase/age reference model.
module tb_pll_lock_supervisor;

  localparam int P_RST = 4;
  localparam int P_TMO = 32;
  localparam int P_STB = 8;
  localparam int P_MAX = 2;

  localparam int M_PRST = 0;
  localparam int M_WAIT = 1;
  localparam int M_STAB = 2;
  localparam int M_RUN  = 3;
  localparam int M_FAIL = 4;

  logic refclk = 1'b0;
  logic rst_n  = 1'b0;

  pll_lock_supervisor_if bus ();

  pll_lock_supervisor #(
    .PLL_RST_CYCLES     (P_RST),
    .LOCK_TIMEOUT_CYCLES(P_TMO),
    .LOCK_STABLE_CYCLES (P_STB),
    .MAX_RETRIES        (P_MAX)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .sup   (bus)
  );

  always #10 refclk = ~refclk;

  int   checks = 0;
  int   errors = 0;

  int   m_phase;
  int   m_age;
  int   m_retry;
  logic m_s1;
  logic m_lk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_phase = M_PRST;
    m_age   = 0;
    m_retry = 0;
    m_s1    = 1'b0;
    m_lk    = 1'b0;
  endfunction

  // Phase is left after it has lasted its programmed number of cycles (age counts up).
  function automatic void model_step(input logic locked, input logic relock);
    logic seen;
    int   nxt;
    seen = m_lk;
    m_lk = m_s1;
    m_s1 = locked;
    nxt  = m_phase;
    case (m_phase)
      M_PRST: if (m_age == P_RST - 1) nxt = M_WAIT;
      M_WAIT: begin
        if (seen) nxt = M_STAB;
        else if (m_age == P_TMO - 1) begin
          m_retry++;
          nxt = (m_retry == P_MAX) ? M_FAIL : M_PRST;
        end
      end
      M_STAB: begin
        if (!seen) nxt = M_WAIT;
        else if (m_age == P_STB - 1) nxt = M_RUN;
      end
      M_RUN:  if (!seen || relock) nxt = M_PRST;
      default: if (relock) begin
        m_retry = 0;
        nxt = M_PRST;
      end
    endcase
    if (nxt != m_phase) begin
      m_age = 0;
      if (nxt == M_RUN) m_retry = 0;
    end else begin
      m_age++;
    end
    m_phase = nxt;
  endfunction

  task automatic tick();
    @(posedge refclk);
    if (!rst_n) model_reset();
    else model_step(bus.pll_locked, bus.sw_relock);
    @(negedge refclk);
    check("model_pll_rst", 32'(bus.pll_rst), 32'(m_phase == M_PRST));
    check("model_sys_rst_n", 32'(bus.sys_rst_n), 32'(m_phase == M_RUN));
    check("model_lock_fail", 32'(bus.lock_fail), 32'(m_phase == M_FAIL));
    check("model_retry_count", 32'(bus.retry_count), 32'(m_retry));
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return bus.pll_rst;
      1:       return bus.sys_rst_n;
      default: return bus.lock_fail;
    endcase
  endfunction

  task automatic count_until(input int sel, input logic val, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      tick();
      n++;
      if (sig(sel) === val) break;
    end
  endtask

  task automatic reach_stable(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (m_phase == M_STAB) begin
        ok = 1'b1;
        break;
      end
      bus.sw_relock = (m_phase == M_FAIL || m_phase == M_RUN);
      tick();
    end
    bus.sw_relock = 1'b0;
  endtask

  initial begin
    int   n;
    int   hold;
    logic ok;

    bus.pll_locked = 1'b0;
    bus.sw_relock  = 1'b0;
    model_reset();

    // Reset state
    repeat (3) tick();
    check("reset_pll_rst", 32'(bus.pll_rst), 32'd1);
    check("reset_sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
    check("reset_lock_fail", 32'(bus.lock_fail), 32'd0);
    check("reset_retry", 32'(bus.retry_count), 32'd0);

    // Normal bring-up
    rst_n = 1'b1;
    count_until(0, 1'b0, 50, n);
    check("bringup_pll_rst_len", n, P_RST);
    repeat (10 - P_RST) tick();
    bus.pll_locked = 1'b1;
    count_until(1, 1'b1, 100, n);
    check("bringup_lock_to_release", n, 2 + 1 + P_STB);
    check("bringup_retry", 32'(bus.retry_count), 32'd0);
    $display("bring-up: released %0d cycles after lock", n);

    // Software relock from RUN
    bus.sw_relock = 1'b1;
    tick();
    bus.sw_relock = 1'b0;
    check("swrelock_sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
    check("swrelock_pll_rst", 32'(bus.pll_rst), 32'd1);

    // Unstable lock inside STABLE
    reach_stable(ok);
    check("unstable_reach_stable", 32'(ok), 32'd1);
    repeat (2) tick();
    bus.pll_locked = 1'b0;
    repeat (3) tick();
    bus.pll_locked = 1'b1;
    count_until(1, 1'b1, 100, n);
    check("unstable_fresh_window", n, 2 + 1 + P_STB);
    check("unstable_retry", 32'(bus.retry_count), 32'd0);
    $display("unstable lock: released %0d cycles after lock returned", n);

    // Lock loss in RUN
    bus.pll_locked = 1'b0;
    repeat (2) tick();
    check("loss_sys_still_high", 32'(bus.sys_rst_n), 32'd1);
    tick();
    check("loss_sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
    check("loss_pll_rst", 32'(bus.pll_rst), 32'd1);
    count_until(0, 1'b0, 50, n);
    check("loss_pll_rst_len", n, P_RST);

    // Timeouts leading to FAIL
    count_until(0, 1'b1, 100, n);
    check("timeout1_wait", n, P_TMO);
    check("timeout1_retry", 32'(bus.retry_count), 32'd1);
    count_until(0, 1'b0, 50, n);
    check("timeout_pll_rst_len", n, P_RST);
    count_until(2, 1'b1, 100, n);
    check("timeout2_wait", n, P_TMO);
    check("fail_retry", 32'(bus.retry_count), 32'(P_MAX));
    check("fail_pll_rst", 32'(bus.pll_rst), 32'd0);
    repeat (40) tick();
    check("fail_held", 32'(bus.lock_fail), 32'd1);
    check("fail_pll_rst_held", 32'(bus.pll_rst), 32'd0);
    $display("timeout: lock_fail=%0d retry_count=%0d", bus.lock_fail, bus.retry_count);

    // Recovery from FAIL
    bus.sw_relock  = 1'b1;
    bus.pll_locked = 1'b1;
    tick();
    bus.sw_relock = 1'b0;
    check("recover_lock_fail", 32'(bus.lock_fail), 32'd0);
    check("recover_retry", 32'(bus.retry_count), 32'd0);
    check("recover_pll_rst", 32'(bus.pll_rst), 32'd1);
    count_until(0, 1'b0, 50, n);
    check("recover_pll_rst_len", n, P_RST);
    count_until(1, 1'b1, 50, n);
    check("recover_release", n, 1 + P_STB);
    $display("recovery: released %0d cycles after pll_rst dropped", n);

    // Random lock activity and relock requests
    for (int i = 0; i < 60; i++) begin
      bus.pll_locked = 1'($urandom_range(0, 1));
      hold = $urandom_range(1, 50);
      for (int j = 0; j < hold; j++) begin
        bus.sw_relock = ($urandom_range(0, 15) == 0);
        tick();
      end
    end
    bus.sw_relock = 1'b0;
    $display("random phase: %0d checks so far", checks);

    // Asynchronous reset in the middle of STABLE
    bus.pll_locked = 1'b1;
    reach_stable(ok);
    check("async_reach_stable", 32'(ok), 32'd1);
    tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("async_pll_rst", 32'(bus.pll_rst), 32'd1);
    check("async_sys_rst_n", 32'(bus.sys_rst_n), 32'd0);
    check("async_lock_fail", 32'(bus.lock_fail), 32'd0);
    check("async_retry", 32'(bus.retry_count), 32'd0);
    $display("async reset: pll_rst=%0d sys_rst_n=%0d before next edge", bus.pll_rst, bus.sys_rst_n);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    check("post_reset_run", 32'(bus.sys_rst_n), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Supervises the `pll_0002` clock generator from the 50 MHz reference domain. It drives the PLL reset, qualifies the asynchronous `locked` output, and releases a system reset only after lock has been stable for a programmed time. Lock loss triggers automatic relock, with bounded retries and a sticky failure flag. It sits directly between the board reset/reference clock and the PLL, and gates reset for all logic clocked by the PLL outputs.

## Interface
Parameters:
- `PLL_RST_CYCLES`, 50: refclk cycles `pll_rst` is held high per reset attempt (≥ 1 µs at 50 MHz).
- `LOCK_TIMEOUT_CYCLES`, 50000: cycles allowed in WAIT_LOCK before an attempt counts as failed.
- `LOCK_STABLE_CYCLES`, 5000: consecutive cycles synchronized lock must stay high before release.
- `MAX_RETRIES`, 3: failed attempts before entering FAIL; range 1..15.

Ports:
- `refclk`  in  1: 50 MHz reference clock, the same net that feeds the PLL.
- `rst_n`  in  1: asynchronous active-low reset. Deassertion is synchronized by the board reset path.
- `pll_locked`  in  1: PLL `locked`, asynchronous to `refclk`.
- `sw_relock`  in  1: single-cycle synchronous request to restart the PLL.
- `pll_rst`  out  1: active-high reset to the PLL.
- `sys_rst_n`  out  1: active-low reset for downstream logic; 1 only in RUN.
- `lock_fail`  out  1: sticky; 1 only in FAIL.
- `retry_count`  out  4: number of failed attempts since last RUN or clear.

## Operation
- `pll_locked` passes through a 2-flop synchronizer to produce `lk`. All decisions use `lk` only.
- One down-counter `cnt`, sized by `$clog2` of the largest cycle parameter. It is reloaded on every state entry.
- All outputs are registered. Reset values: state=PLL_RST, `pll_rst`=1, `sys_rst_n`=0, `lock_fail`=0, `retry_count`=0, `cnt`=PLL_RST_CYCLES-1.
- PLL_RST (`pll_rst`=1)
  - When `cnt`==0, go to WAIT_LOCK.
- WAIT_LOCK (`pll_rst`=0)
  - If `lk`=1, go to STABLE.
  - Else if `cnt`==0, increment `retry_count`. If the new value == MAX_RETRIES, go to FAIL; otherwise go to PLL_RST.
- STABLE
  - If `lk`=0, go to WAIT_LOCK. This reloads the timeout and does not count as a retry.
  - Else if `cnt`==0, go to RUN.
- RUN (`sys_rst_n`=1)
  - On entry, clear `retry_count`.
  - If `lk`=0, go to PLL_RST.
  - If `sw_relock`=1, go to PLL_RST.
- FAIL (`lock_fail`=1, `pll_rst`=0, `sys_rst_n`=0)
  - Held until `rst_n` asserts or `sw_relock`=1.
  - `sw_relock` clears `retry_count` and `lock_fail` and goes to PLL_RST.
- `sw_relock` is ignored in PLL_RST, WAIT_LOCK and STABLE.
- Simultaneous events in RUN: `lk` falling together with `sw_relock` gives a single transition to PLL_RST.
- Simultaneous events in WAIT_LOCK: `lk`=1 on the timeout cycle counts as lock (go to STABLE, no retry).
- `rst_n` assertion mid-operation forces all reset values immediately, without waiting for a clock edge.

## Timing
- Synchronizer latency is 2 cycles from a `pll_locked` edge to `lk`.
- `pll_rst` is high for exactly PLL_RST_CYCLES cycles per attempt, including the first attempt after reset.
- Minimum from `pll_locked` rising to `sys_rst_n` rising is 2 + 1 + LOCK_STABLE_CYCLES cycles.
- `sys_rst_n` falls 3 cycles after `pll_locked` falls in RUN (sync 2 + register 1).
- `sys_rst_n` falls 1 cycle after `sw_relock` in RUN.
- `pll_rst` rises on the same edge that `sys_rst_n` falls.
- A lock glitch shorter than 1 refclk cycle may be missed. This is acceptable; the PLL holds `locked` low for multiple cycles on real loss.

## Structure
- Package `pll_sup_pkg` holds:
  - the state enum (PLL_RST, WAIT_LOCK, STABLE, RUN, FAIL);
  - `RETRY_W`=4;
  - a function returning the counter width from the parameters.
- Sub-module `bit_sync_2ff`: a generic 2-flop synchronizer with asynchronous active-low reset to 0. It is reused by later PLL-domain reset bridges.
- The supervisor module holds the FSM, the counter and the output registers.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, MAX_RETRIES=2.

- Normal bring-up: release `rst_n`, raise `pll_locked` 10 cycles later.
  - `pll_rst` is high for exactly 4 cycles.
  - `sys_rst_n` rises 11 cycles after `pll_locked` rises.
  - `retry_count`=0.
- Unstable lock: in STABLE, drop `pll_locked` for 3 cycles at stable count 5, then hold it high.
  - No retry is counted.
  - `sys_rst_n` rises only after a fresh 8-cycle stable window.
- Lock loss in RUN: drop `pll_locked`.
  - `sys_rst_n`=0 and `pll_rst`=1 three cycles later.
  - `pll_rst` is held 4 cycles, then relock proceeds.
- Timeout and fail: keep `pll_locked`=0.
  - Two 4-cycle `pll_rst` pulses, each separated by 32 cycles of waiting.
  - Then `lock_fail`=1 and `retry_count`=2, with `pll_rst`=0 held.
- Recovery from FAIL: pulse `sw_relock`, raise `pll_locked`.
  - `lock_fail`=0, `retry_count`=0, a new 4-cycle `pll_rst`, then normal release.
- Asynchronous reset mid-STABLE: assert `rst_n` between clock edges.
  - `pll_rst`=1 and `sys_rst_n`=0 immediately, before the next clock edge.
